// File: rtl/reset_sequencer_if.sv
// Board reset sequencer bus: raw button and MMCM lock inputs, conditioned reset and debug status outputs.
// The slave modport is the sequencer; the master modport is the board side that supplies the raw inputs.
interface reset_sequencer_if;
   logic       btn_in;
   logic       pll_locked;
   logic       core_rst;
   logic       core_rst_n;
   logic       btn_db;
   logic [1:0] state;
   logic [7:0] reset_count;

   modport slave (
      input  btn_in,
      input  pll_locked,
      output core_rst,
      output core_rst_n,
      output btn_db,
      output state,
      output reset_count
   );

   modport master (
      output btn_in,
      output pll_locked,
      input  core_rst,
      input  core_rst_n,
      input  btn_db,
      input  state,
      input  reset_count
   );
endinterface

// File: rtl/reset_sequencer.sv
// Button debounce plus MMCM-lock qualification driving a stretched, registered SoC core reset.
// Latency from rst release with lock high: 2 + LOCK_STABLE_CYCLES + RESET_HOLD_CYCLES edges; no backpressure.
module reset_sequencer #(
   parameter int DEBOUNCE_CYCLES    = 20000,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int RESET_HOLD_CYCLES  = 16
) (
   input  logic             clk,
   input  logic             rst,
   reset_sequencer_if.slave bus
);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int LK_W = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int HD_W = $clog2(RESET_HOLD_CYCLES + 1);

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [HD_W-1:0] HD_LAST = HD_W'(RESET_HOLD_CYCLES - 1);

   localparam logic [1:0] ST_ASSERT    = 2'd0;
   localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
   localparam logic [1:0] ST_HOLD      = 2'd2;
   localparam logic [1:0] ST_RUN       = 2'd3;

   logic            btn_meta_q, btn_meta_d;
   logic            btn_sync_q, btn_sync_d;
   logic            lock_meta_q, lock_meta_d;
   logic            lock_sync_q, lock_sync_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            btn_db_q, btn_db_d;
   logic [LK_W-1:0] lock_cnt_q, lock_cnt_d;
   logic [HD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [1:0]      state_q, state_d;
   logic [7:0]      reset_count_q, reset_count_d;
   logic            core_rst_q, core_rst_d;
   logic            core_rst_n_q, core_rst_n_d;

   always_comb begin
      btn_meta_d  = bus.btn_in;
      btn_sync_d  = btn_meta_q;
      lock_meta_d = bus.pll_locked;
      lock_sync_d = lock_meta_q;
   end

   // Any cycle where the synchronized level agrees with btn_db restarts the debounce window.
   always_comb begin
      btn_db_d = btn_db_q;
      db_cnt_d = '0;
      if (btn_sync_q != btn_db_q) begin
         if (db_cnt_q == DB_LAST) begin
            btn_db_d = ~btn_db_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   // Counters default to zero so each one restarts from 0 whenever its state is (re)entered.
   always_comb begin
      state_d       = state_q;
      lock_cnt_d    = '0;
      hold_cnt_d    = '0;
      reset_count_d = reset_count_q;
      case (state_q)
         ST_ASSERT: begin
            if (!btn_db_q) state_d = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (btn_db_q) begin
               state_d = ST_ASSERT;
            end else if (lock_sync_q) begin
               if (lock_cnt_q == LK_LAST) state_d = ST_HOLD;
               else                       lock_cnt_d = lock_cnt_q + 1'b1;
            end
         end
         ST_HOLD: begin
            if (btn_db_q) begin
               state_d = ST_ASSERT;
            end else if (!lock_sync_q) begin
               state_d = ST_WAIT_LOCK;
            end else if (hold_cnt_q == HD_LAST) begin
               state_d = ST_RUN;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (btn_db_q || !lock_sync_q) begin
               state_d = btn_db_q ? ST_ASSERT : ST_WAIT_LOCK;
               if (reset_count_q != 8'hFF) reset_count_d = reset_count_q + 8'd1;
            end
         end
         default: state_d = ST_ASSERT;
      endcase
   end

   // Reset outputs follow the next state so core_rst is low exactly while state_q is RUN.
   always_comb begin
      core_rst_d   = (state_d != ST_RUN);
      core_rst_n_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_meta_q    <= 1'b0;
         btn_sync_q    <= 1'b0;
         lock_meta_q   <= 1'b0;
         lock_sync_q   <= 1'b0;
         db_cnt_q      <= '0;
         btn_db_q      <= 1'b0;
         lock_cnt_q    <= '0;
         hold_cnt_q    <= '0;
         state_q       <= ST_ASSERT;
         reset_count_q <= 8'd0;
         core_rst_q    <= 1'b1;
         core_rst_n_q  <= 1'b0;
      end else begin
         btn_meta_q    <= btn_meta_d;
         btn_sync_q    <= btn_sync_d;
         lock_meta_q   <= lock_meta_d;
         lock_sync_q   <= lock_sync_d;
         db_cnt_q      <= db_cnt_d;
         btn_db_q      <= btn_db_d;
         lock_cnt_q    <= lock_cnt_d;
         hold_cnt_q    <= hold_cnt_d;
         state_q       <= state_d;
         reset_count_q <= reset_count_d;
         core_rst_q    <= core_rst_d;
         core_rst_n_q  <= core_rst_n_d;
      end
   end

   assign bus.core_rst    = core_rst_q;
   assign bus.core_rst_n  = core_rst_n_q;
   assign bus.btn_db      = btn_db_q;
   assign bus.state       = state_q;
   assign bus.reset_count = reset_count_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with DEBOUNCE=4, LOCK_STABLE=8, RESET_HOLD=3.
// Edge counts are relative to the last input change, which is applied 1 time unit after a rising edge.
module tb_reset_sequencer;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   reset_sequencer_if bus ();

   reset_sequencer #(
      .DEBOUNCE_CYCLES    (4),
      .LOCK_STABLE_CYCLES (8),
      .RESET_HOLD_CYCLES  (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_state(input int s, input int budget, input string tag);
      int k;
      k = 0;
      while (int'(bus.state) != s && k < budget) begin
         step(1);
         k++;
      end
      if (int'(bus.state) != s) check_val(tag, int'(bus.state), s);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cr_fall;
      int db_rise;
      int db_fall;
      int saw;

      // Power-up
      rst = 1'b1;
      bus.btn_in = 1'b0;
      bus.pll_locked = 1'b1;
      step(1);
      check_val("rst_core_rst", int'(bus.core_rst), 1);
      check_val("rst_core_rst_n", int'(bus.core_rst_n), 0);
      check_val("rst_state", int'(bus.state), 0);
      check_val("rst_btn_db", int'(bus.btn_db), 0);
      check_val("rst_count", int'(bus.reset_count), 0);
      step(2);
      check_val("rst_state_held", int'(bus.state), 0);
      rst = 1'b0;
      cr_fall = 0;
      for (int e = 1; e <= 20; e++) begin
         step(1);
         if (e == 1)  check_val("pwrup_wait_lock", int'(bus.state), 1);
         if (e == 9)  check_val("pwrup_still_wait", int'(bus.state), 1);
         if (e == 10) check_val("pwrup_hold", int'(bus.state), 2);
         if (e == 12) check_val("pwrup_rst_high_e12", int'(bus.core_rst), 1);
         if (cr_fall == 0 && bus.core_rst == 1'b0) cr_fall = e;
      end
      check_val("pwrup_latency", cr_fall, 13);
      check_val("pwrup_run", int'(bus.state), 3);
      check_val("pwrup_core_rst_n", int'(bus.core_rst_n), 1);
      check_val("pwrup_count", int'(bus.reset_count), 0);

      // Short button bounces never reach btn_db
      for (int p = 1; p <= 3; p++) begin
         saw = 0;
         bus.btn_in = 1'b1;
         step(p);
         bus.btn_in = 1'b0;
         for (int k = 0; k < 10; k++) begin
            step(1);
            if (bus.btn_db || bus.core_rst || bus.state != 2'd3) saw = 1;
         end
         check_val($sformatf("bounce_%0d_disturbed", p), saw, 0);
      end

      // Button held 10 cycles in RUN
      db_rise = 0;
      bus.btn_in = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         step(1);
         if (db_rise == 0 && bus.btn_db == 1'b1) db_rise = e;
         if (e == 6) check_val("btn_run_still_e6", int'(bus.core_rst), 0);
         if (e == 7) begin
            check_val("btn_core_rst", int'(bus.core_rst), 1);
            check_val("btn_state", int'(bus.state), 0);
            check_val("btn_count", int'(bus.reset_count), 1);
         end
      end
      check_val("btn_db_rise_edge", db_rise, 6);
      check_val("btn_held_state", int'(bus.state), 0);
      bus.btn_in = 1'b0;
      db_fall = 0;
      cr_fall = 0;
      for (int e = 1; e <= 30; e++) begin
         step(1);
         if (db_fall == 0 && bus.btn_db == 1'b0) db_fall = e;
         if (cr_fall == 0 && bus.core_rst == 1'b0) cr_fall = e;
      end
      check_val("btn_db_fall_edge", db_fall, 6);
      check_val("btn_release_latency", cr_fall, 18);
      check_val("btn_release_count", int'(bus.reset_count), 1);

      // One-cycle lock glitch in RUN
      bus.pll_locked = 1'b0;
      step(1);
      bus.pll_locked = 1'b1;
      step(1);
      check_val("glitch_run_e2", int'(bus.state), 3);
      step(1);
      check_val("glitch_run_state", int'(bus.state), 1);
      check_val("glitch_run_core_rst", int'(bus.core_rst), 1);
      check_val("glitch_run_count", int'(bus.reset_count), 2);

      // One-cycle lock glitch just after entering HOLD
      wait_state(2, 20, "glitch_reach_hold");
      bus.pll_locked = 1'b0;
      step(1);
      bus.pll_locked = 1'b1;
      cr_fall = 0;
      for (int e = 2; e <= 20; e++) begin
         step(1);
         if (e == 3)  check_val("glitch_hold_state", int'(bus.state), 1);
         if (e == 13) check_val("glitch_hold_restart", int'(bus.state), 2);
         if (cr_fall == 0 && bus.core_rst == 1'b0) cr_fall = e;
      end
      check_val("glitch_hold_latency", cr_fall, 14);
      check_val("glitch_hold_count", int'(bus.reset_count), 2);

      // Saturating event counter
      for (int i = 0; i < 300; i++) begin
         bus.pll_locked = 1'b0;
         step(1);
         bus.pll_locked = 1'b1;
         wait_state(1, 10, "sat_leave_run");
         wait_state(3, 40, "sat_back_to_run");
      end
      check_val("sat_count", int'(bus.reset_count), 255);

      // Synchronous reset in the middle of HOLD
      bus.pll_locked = 1'b0;
      step(1);
      bus.pll_locked = 1'b1;
      wait_state(2, 40, "midop_reach_hold");
      step(1);
      check_val("midop_in_hold", int'(bus.state), 2);
      rst = 1'b1;
      step(1);
      check_val("midop_count", int'(bus.reset_count), 0);
      check_val("midop_state", int'(bus.state), 0);
      check_val("midop_btn_db", int'(bus.btn_db), 0);
      check_val("midop_core_rst", int'(bus.core_rst), 1);
      check_val("midop_core_rst_n", int'(bus.core_rst_n), 0);
      rst = 1'b0;
      wait_state(3, 40, "midop_recover");

      // btn_db rise and lock loss seen by the FSM on the same edge
      bus.btn_in = 1'b1;
      step(4);
      bus.pll_locked = 1'b0;
      step(2);
      check_val("simul_btn_db_e6", int'(bus.btn_db), 1);
      check_val("simul_run_e6", int'(bus.state), 3);
      step(1);
      check_val("simul_state", int'(bus.state), 0);
      check_val("simul_count", int'(bus.reset_count), 1);
      check_val("simul_core_rst", int'(bus.core_rst), 1);
      step(3);
      check_val("simul_count_stable", int'(bus.reset_count), 1);
      bus.btn_in = 1'b0;
      bus.pll_locked = 1'b1;
      wait_state(3, 60, "simul_recover");
      check_val("simul_final_count", int'(bus.reset_count), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
